// File: rtl/mem_lsu_if.sv
// Request, writeback and narrow memory-port signals of the load/store unit.
// slave is the LSU view; master is the requester/memory side.
interface mem_lsu_if #(
  parameter int ADDR_W     = 32,
  parameter int PORT_BYTES = 1
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_store;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [ADDR_W-1:0]       req_addr;
  logic [31:0]             req_wdata;
  logic [4:0]              req_rd;

  logic                    wb_valid;
  logic [4:0]              wb_rd;
  logic [31:0]             wb_data;
  logic                    done;
  logic                    misalign;

  logic                    mem_re;
  logic [ADDR_W-1:0]       mem_raddr;
  logic [8*PORT_BYTES-1:0] mem_rdata;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_waddr;
  logic [8*PORT_BYTES-1:0] mem_wdata;
  logic [PORT_BYTES-1:0]   mem_wmask;

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  mem_rdata,
    output req_ready, wb_valid, wb_rd, wb_data, done, misalign,
    output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output mem_rdata,
    input  req_ready, wb_valid, wb_rd, wb_data, done, misalign,
    input  mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store engine: splits each access into beats on a PORT_BYTES-wide memory port,
// waits RD_LAT cycles per load beat and returns a sign/zero-extended writeback.
module mem_lsu #(
  parameter int ADDR_W     = 32,
  parameter int PORT_BYTES = 1,
  parameter int RD_LAT     = 2
) (
  input  logic     clk,
  input  logic     rst,
  mem_lsu_if.slave bus
);
  // state | meaning
  // IDLE  | ready for a request
  // ISSUE | one read or write strobe for the current beat
  // WAIT  | read latency countdown, data sampled when it expires
  // FIN   | done pulse, writeback for loads
  // FAULT | done + misalign pulse, no memory access
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIN, FAULT} state_t;

  localparam int PW = 8 * PORT_BYTES;

  state_t            state, state_nxt;
  logic              op_store, op_uns;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wbytes [4];
  logic [7:0]        data [4];
  logic [4:0]        rd;
  logic [1:0]        beat;
  logic [2:0]        lat_cnt;

  logic              req_mis, last_beat, beat_done;
  logic [2:0]        req_nbytes;
  logic [4:0]        beat_off;
  logic [ADDR_W-1:0] beat_addr;
  logic [PW-1:0]     wlanes;
  logic [PORT_BYTES-1:0] wmask;
  logic [31:0]       data_w, ext_w;

  always_comb begin
    req_nbytes = 3'd4;
    case (bus.req_size)
      2'd0:    req_nbytes = 3'd1;
      2'd1:    req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
  end

  assign req_mis   = (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                     (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
  assign beat_off  = 5'(beat) * 5'(PORT_BYTES);
  assign beat_addr = addr + ADDR_W'(beat_off);
  assign last_beat = (beat_off + 5'(PORT_BYTES)) >= {2'b00, nbytes};
  assign beat_done = (state == ISSUE && op_store) || (state == WAIT && lat_cnt == 3'd0);
  assign data_w    = {data[3], data[2], data[1], data[0]};

  // Lanes beyond the access size carry no data and are masked off.
  always_comb begin
    wlanes = '0;
    wmask  = '0;
    for (int k = 0; k < PORT_BYTES; k++) begin
      if ((beat_off + 5'(k)) < {2'b00, nbytes}) begin
        wmask[k]          = 1'b1;
        wlanes[8*k +: 8]  = wbytes[2'(beat_off + 5'(k))];
      end
    end
  end

  always_comb begin
    ext_w = data_w;
    case (nbytes)
      3'd1:    ext_w = op_uns ? {24'b0, data_w[7:0]}  : {{24{data_w[7]}}, data_w[7:0]};
      3'd2:    ext_w = op_uns ? {16'b0, data_w[15:0]} : {{16{data_w[15]}}, data_w[15:0]};
      default: ext_w = data_w;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_raddr = '0;
    bus.mem_we    = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    bus.done      = 1'b0;
    bus.misalign  = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = req_mis ? FAULT : ISSUE;
      end
      ISSUE: begin
        if (op_store) begin
          bus.mem_we    = 1'b1;
          bus.mem_waddr = beat_addr;
          bus.mem_wdata = wlanes;
          bus.mem_wmask = wmask;
          state_nxt     = last_beat ? FIN : ISSUE;
        end else begin
          bus.mem_re    = 1'b1;
          bus.mem_raddr = beat_addr;
          state_nxt     = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == 3'd0) state_nxt = last_beat ? FIN : ISSUE;
      end
      FIN: begin
        bus.done = 1'b1;
        if (!op_store) begin
          bus.wb_valid = 1'b1;
          bus.wb_rd    = rd;
          bus.wb_data  = ext_w;
        end
        state_nxt = IDLE;
      end
      FAULT: begin
        bus.done     = 1'b1;
        bus.misalign = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_store <= 1'b0;
      op_uns   <= 1'b0;
      nbytes   <= 3'd0;
      addr     <= '0;
      rd       <= '0;
      beat     <= '0;
      lat_cnt  <= '0;
      for (int i = 0; i < 4; i++) begin
        wbytes[i] <= '0;
        data[i]   <= '0;
      end
    end else if (state == IDLE && bus.req_valid) begin
      op_store <= bus.req_store;
      op_uns   <= bus.req_unsigned;
      nbytes   <= req_nbytes;
      addr     <= bus.req_addr;
      rd       <= bus.req_rd;
      beat     <= '0;
      lat_cnt  <= '0;
      for (int i = 0; i < 4; i++) begin
        wbytes[i] <= bus.req_wdata[8*i +: 8];
        data[i]   <= '0;
      end
    end else begin
      // Count includes the strobe cycle, so WAIT lasts exactly RD_LAT cycles.
      if (state == ISSUE && !op_store)            lat_cnt <= 3'(RD_LAT - 1);
      else if (state == WAIT && lat_cnt != 3'd0)  lat_cnt <= lat_cnt - 3'd1;
      if (state == WAIT && lat_cnt == 3'd0) begin
        for (int k = 0; k < PORT_BYTES; k++) begin
          if ((beat_off + 5'(k)) < {2'b00, nbytes})
            data[2'(beat_off + 5'(k))] <= bus.mem_rdata[8*k +: 8];
        end
      end
      if (beat_done) beat <= beat + 2'd1;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: instance 0 has a 1-byte port / RD_LAT 2, instance 1 a 4-byte port / RD_LAT 1.
// Table vectors, randomized accesses against a transaction-level model, and reset/back-to-back sequences.
module tb_mem_lsu;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  wire [1:0]        o_ready, o_wb_valid, o_done, o_misalign, o_re, o_we;
  wire [1:0][4:0]   o_wb_rd;
  wire [1:0][31:0]  o_wb_data, o_raddr, o_waddr, o_wdata;
  wire [1:0][3:0]   o_wmask;

  logic [7:0] mem [0:4095];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int PB = (g == 0) ? 1 : 4;
    localparam int RL = (g == 0) ? 2 : 1;

    mem_lsu_if #(.ADDR_W(ADDR_W), .PORT_BYTES(PB)) bus ();
    mem_lsu #(.ADDR_W(ADDR_W), .PORT_BYTES(PB), .RD_LAT(RL)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.req_valid    = req_valid[g];
    assign bus.req_store    = req_store;
    assign bus.req_size     = req_size;
    assign bus.req_unsigned = req_unsigned;
    assign bus.req_addr     = req_addr;
    assign bus.req_wdata    = req_wdata;
    assign bus.req_rd       = req_rd;

    assign o_ready[g]    = bus.req_ready;
    assign o_wb_valid[g] = bus.wb_valid;
    assign o_wb_rd[g]    = bus.wb_rd;
    assign o_wb_data[g]  = bus.wb_data;
    assign o_done[g]     = bus.done;
    assign o_misalign[g] = bus.misalign;
    assign o_re[g]       = bus.mem_re;
    assign o_raddr[g]    = bus.mem_raddr;
    assign o_we[g]       = bus.mem_we;
    assign o_waddr[g]    = bus.mem_waddr;
    assign o_wdata[g]    = 32'(bus.mem_wdata);
    assign o_wmask[g]    = 4'(bus.mem_wmask);

    // Read data is valid only in the RL-th cycle after the strobe; junk otherwise.
    logic [RL-1:0] pv;
    logic [31:0]   pd [RL];
    logic [31:0]   junk;
    always @(posedge clk) begin
      junk  <= $urandom;
      pv[0] <= bus.mem_re;
      pd[0] <= {mem[12'(bus.mem_raddr + 32'd3)], mem[12'(bus.mem_raddr + 32'd2)],
                mem[12'(bus.mem_raddr + 32'd1)], mem[12'(bus.mem_raddr)]};
      for (int j = 1; j < RL; j++) begin
        pv[j] <= pv[j-1];
        pd[j] <= pd[j-1];
      end
    end
    assign bus.mem_rdata = pv[RL-1] ? pd[RL-1][8*PB-1:0] : junk[8*PB-1:0];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  int          obs_done_cyc;
  logic        obs_mis, obs_wbv;
  logic [31:0] obs_wbd;
  logic [4:0]  obs_wbr;
  int          obs_hyg;
  logic [31:0] obs_ra[$];
  int          obs_rc[$];
  logic [31:0] obs_wa[$];
  logic [31:0] obs_wd[$];
  logic [3:0]  obs_wm[$];
  int          obs_wc[$];

  task automatic run_access(input string tag, input int sel, input logic st, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd);
    obs_ra.delete(); obs_rc.delete();
    obs_wa.delete(); obs_wd.delete(); obs_wm.delete(); obs_wc.delete();
    obs_hyg = 0; obs_done_cyc = -1;
    obs_mis = 1'b0; obs_wbv = 1'b0; obs_wbd = '0; obs_wbr = '0;
    @(negedge clk);
    req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 2'b00;
    req_valid[sel] = 1'b1;
    check({tag, ".ready"}, 32'(o_ready[sel]), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    for (int n = 1; n <= 40 && obs_done_cyc < 0; n++) begin
      @(negedge clk);
      if (o_re[sel]) begin obs_ra.push_back(o_raddr[sel]); obs_rc.push_back(n); end
      else if (o_raddr[sel] != 0) obs_hyg++;
      if (o_we[sel]) begin
        obs_wa.push_back(o_waddr[sel]); obs_wd.push_back(o_wdata[sel]);
        obs_wm.push_back(o_wmask[sel]); obs_wc.push_back(n);
      end else if (o_waddr[sel] != 0 || o_wdata[sel] != 0 || o_wmask[sel] != 0) obs_hyg++;
      if (!o_wb_valid[sel] && (o_wb_data[sel] != 0 || o_wb_rd[sel] != 0)) obs_hyg++;
      if (o_ready[sel]) obs_hyg++;
      if ((o_wb_valid[sel] || o_misalign[sel]) && !o_done[sel]) obs_hyg++;
      if (o_re[1-sel] || o_we[1-sel] || o_done[1-sel]) obs_hyg++;
      if (o_done[sel]) begin
        obs_done_cyc = n;
        obs_mis = o_misalign[sel];
        obs_wbv = o_wb_valid[sel];
        obs_wbd = o_wb_data[sel];
        obs_wbr = o_wb_rd[sel];
      end
    end
    @(negedge clk);
    if (!o_ready[sel] || o_done[sel] || o_wb_valid[sel] || o_re[sel] || o_we[sel]) obs_hyg++;
  endtask

  // Expected behaviour from access size, port width and latency rules.
  task automatic model_check(input string tag, input int sel, input logic st, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd);
    int nb, pb, rl, beats, lat;
    logic mis, wbv;
    logic [31:0] v, ed, lm;
    logic [3:0] em;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    pb = (sel != 0) ? 4 : 1;
    rl = (sel != 0) ? 1 : 2;
    mis = (addr % 32'(nb)) != 0;
    beats = (nb + pb - 1) / pb;
    lat = mis ? 1 : (st ? beats + 1 : beats * (1 + rl) + 1);
    wbv = !st && !mis;
    v = '0;
    for (int j = 0; j < nb; j++) v |= 32'(mem[12'(addr + 32'(j))]) << (8 * j);
    if (!uns && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8 * nb)) - 32'd1);

    check({tag, ".lat"}, obs_done_cyc, lat);
    check({tag, ".misalign"}, 32'(obs_mis), 32'(mis));
    check({tag, ".wb_valid"}, 32'(obs_wbv), 32'(wbv));
    check({tag, ".wb_data"}, obs_wbd, wbv ? v : 32'd0);
    check({tag, ".wb_rd"}, 32'(obs_wbr), wbv ? 32'(rd) : 32'd0);
    check({tag, ".nreads"}, obs_ra.size(), (st || mis) ? 0 : beats);
    check({tag, ".nwrites"}, obs_wa.size(), (st && !mis) ? beats : 0);
    if (!st && !mis && obs_ra.size() == beats)
      for (int i = 0; i < beats; i++) begin
        check($sformatf("%s.raddr%0d", tag, i), obs_ra[i], addr + 32'(i * pb));
        check($sformatf("%s.rcyc%0d", tag, i), obs_rc[i], 1 + i * (1 + rl));
      end
    if (st && !mis && obs_wa.size() == beats)
      for (int i = 0; i < beats; i++) begin
        em = '0; ed = '0;
        for (int k = 0; k < pb; k++)
          if (i * pb + k < nb) begin
            em[k] = 1'b1;
            ed[8*k +: 8] = wdata[8*(i*pb+k) +: 8];
          end
        lm = {{8{em[3]}}, {8{em[2]}}, {8{em[1]}}, {8{em[0]}}};
        check($sformatf("%s.waddr%0d", tag, i), obs_wa[i], addr + 32'(i * pb));
        check($sformatf("%s.wmask%0d", tag, i), 32'(obs_wm[i]), 32'(em));
        check($sformatf("%s.wdata%0d", tag, i), obs_wd[i] & lm, ed);
        check($sformatf("%s.wcyc%0d", tag, i), obs_wc[i], 1 + i);
      end
    check({tag, ".hygiene"}, obs_hyg, 0);
  endtask

  typedef struct {
    int          sel;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          lat;
    logic        mis;
    logic        wbv;
    logic [31:0] wbd;
  } vec_t;

  vec_t vecs[13];
  int   stray;
  logic [5:0] we_bits, done_bits, rdy_bits;

  initial begin
    vecs[0]  = '{0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        5'd7,  4,  1'b0, 1'b1, 32'hFFFFFF80};
    vecs[1]  = '{0, 1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF, 5'd3,  5,  1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1, 1'b0, 2'd1, 1'b1, 32'h302, 32'h0,        5'd9,  3,  1'b0, 1'b1, 32'h00008001};
    vecs[3]  = '{1, 1'b1, 2'd0, 1'b0, 32'h13,  32'h000000A5, 5'd1,  2,  1'b0, 1'b0, 32'h0};
    vecs[4]  = '{0, 1'b0, 2'd1, 1'b0, 32'h101, 32'h0,        5'd4,  1,  1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        5'd4,  1,  1'b1, 1'b0, 32'h0};
    vecs[6]  = '{0, 1'b0, 2'd1, 1'b0, 32'h302, 32'h0,        5'd12, 7,  1'b0, 1'b1, 32'hFFFF8001};
    vecs[7]  = '{1, 1'b0, 2'd2, 1'b1, 32'h304, 32'h0,        5'd31, 3,  1'b0, 1'b1, 32'h3412AAAA};
    vecs[8]  = '{0, 1'b0, 2'd0, 1'b1, 32'h100, 32'h0,        5'd5,  4,  1'b0, 1'b1, 32'h00000080};
    vecs[9]  = '{1, 1'b0, 2'd3, 1'b0, 32'h304, 32'h0,        5'd2,  3,  1'b0, 1'b1, 32'h3412AAAA};
    vecs[10] = '{0, 1'b0, 2'd2, 1'b0, 32'h304, 32'h0,        5'd17, 13, 1'b0, 1'b1, 32'h3412AAAA};
    vecs[11] = '{0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h12345678, 5'd8,  3,  1'b0, 1'b0, 32'h0};
    vecs[12] = '{0, 1'b1, 2'd2, 1'b0, 32'h201, 32'h12345678, 5'd8,  1,  1'b1, 1'b0, 32'h0};

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h100] = 8'h80;
    mem[12'h302] = 8'h01; mem[12'h303] = 8'h80;
    mem[12'h304] = 8'hAA; mem[12'h305] = 8'hAA;
    mem[12'h306] = 8'h12; mem[12'h307] = 8'h34;

    rst = 1'b0;
    req_valid = 2'b00; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    #12;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset%0d.ready", g), 32'(o_ready[g]), 32'd1);
      check($sformatf("reset%0d.outs", g),
            {o_re[g], o_we[g], o_done[g], o_misalign[g], o_wb_valid[g], |o_wb_data[g],
             |o_wb_rd[g], |o_raddr[g], |o_waddr[g], |o_wdata[g], |o_wmask[g]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_access(tag, vecs[i].sel, vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                 vecs[i].wdata, vecs[i].rd);
      check({tag, ".tlat"}, obs_done_cyc, vecs[i].lat);
      check({tag, ".tmis"}, 32'(obs_mis), 32'(vecs[i].mis));
      check({tag, ".twbv"}, 32'(obs_wbv), 32'(vecs[i].wbv));
      check({tag, ".twbd"}, obs_wbd, vecs[i].wbd);
      model_check(tag, vecs[i].sel, vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                  vecs[i].wdata, vecs[i].rd);
    end

    for (int i = 0; i < 80; i++) begin
      int sel, nb;
      logic st, uns;
      logic [1:0] sz;
      logic [31:0] addr, wdata;
      logic [4:0] rd;
      string tag;
      sel = $urandom_range(0, 1);
      st = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      addr = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nb - 1);
      wdata = $urandom;
      rd = 5'($urandom);
      tag = $sformatf("rnd%0d", i);
      run_access(tag, sel, st, sz, uns, addr, wdata, rd);
      model_check(tag, sel, st, sz, uns, addr, wdata, rd);
    end

    // Reset while a word load is waiting for read data.
    @(negedge clk);
    req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h304; req_rd = 5'd6;
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    check("rstwait.issue_re", 32'(o_re[0]), 32'd1);
    @(negedge clk);
    check("rstwait.in_wait", {31'd0, o_ready[0]}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rstwait.ready", 32'(o_ready[0]), 32'd1);
    check("rstwait.outs",
          {o_re[0], o_we[0], o_done[0], o_misalign[0], o_wb_valid[0], |o_wb_data[0],
           |o_wb_rd[0], |o_raddr[0], |o_waddr[0], |o_wdata[0], |o_wmask[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (o_done[0] || o_wb_valid[0] || o_re[0] || !o_ready[0]) stray++;
    end
    check("rstwait.no_pulse", stray, 0);

    // Reset during a store strobe drops mem_we at once.
    @(negedge clk);
    req_store = 1'b1; req_size = 2'd2; req_addr = 32'h200; req_wdata = 32'hCAFEF00D;
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    check("rstst.we_before", 32'(o_we[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstst.we_after", {o_we[0], |o_waddr[0], |o_wdata[0], |o_wmask[0]}, 32'd0);
    check("rstst.ready", 32'(o_ready[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (o_done[0] || o_we[0] || !o_ready[0]) stray++;
    end
    check("rstst.no_pulse", stray, 0);

    // req_valid held high across FIN: next accept is the cycle after FIN.
    @(negedge clk);
    req_store = 1'b1; req_size = 2'd0; req_addr = 32'h13; req_wdata = 32'h000000A5;
    req_valid = 2'b10;
    we_bits = '0; done_bits = '0; rdy_bits = '0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      we_bits[n-1]   = o_we[1];
      done_bits[n-1] = o_done[1];
      rdy_bits[n-1]  = o_ready[1];
    end
    req_valid = 2'b00;
    check("b2b.we", 32'(we_bits), 32'b001001);
    check("b2b.done", 32'(done_bits), 32'b010010);
    check("b2b.ready", 32'(rdy_bits), 32'b100100);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
